// File: rtl/qspi_arb.sv
// Arbiter/sequencer sharing the single QSPI line-transfer engine between
// icache fills, dcache fills and dcache write-backs.
module qspi_arb #(
    parameter int unsigned PA          = 24,
    parameter int unsigned LINE_LENGTH = 4,
    parameter int unsigned DSTREAK     = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  rom_enable,
    input  logic                                  i_req,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]     i_tag,
    input  logic                                  d_req,
    input  logic                                  d_write,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]     d_tag,
    input  logic                                  q_done,
    output logic                                  q_req,
    output logic                                  q_i_d,
    output logic                                  q_write,
    output logic                                  q_mem,
    output logic [PA-$clog2(LINE_LENGTH)-1:0]     q_paddr,
    output logic                                  i_done,
    output logic                                  d_done,
    output logic                                  busy
);

    localparam int unsigned TW = PA - $clog2(LINE_LENGTH);
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q;
    logic          q_req_q;
    logic          q_i_d_q;
    logic          q_write_q;
    logic          q_mem_q;
    logic [TW-1:0] q_paddr_q;

    logic          any_req_c;
    logic          i_win_c;
    logic          streak_full_c;

    // Dcache wins by default; icache wins when alone or when the dcache streak is exhausted.
    always_comb begin
        any_req_c     = i_req | d_req;
        streak_full_c = (streak_q == SW'(DSTREAK));
        i_win_c       = i_req & (~d_req | streak_full_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            streak_q  <= '0;
            q_req_q   <= 1'b0;
            q_i_d_q   <= 1'b0;
            q_write_q <= 1'b0;
            q_mem_q   <= 1'b0;
            q_paddr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_c) begin
                        state_q   <= S_BUSY;
                        q_req_q   <= 1'b1;
                        q_i_d_q   <= i_win_c;
                        q_write_q <= ~i_win_c & d_write;
                        q_mem_q   <= rom_enable & (i_win_c | ~d_write);
                        q_paddr_q <= i_win_c ? i_tag : d_tag;
                        // Streak only grows while the icache is actually being held off.
                        if (i_win_c || !i_req) begin
                            streak_q <= '0;
                        end else if (!streak_full_c) begin
                            streak_q <= streak_q + SW'(1);
                        end
                    end
                end
                S_BUSY: begin
                    if (q_done) begin
                        state_q <= S_GAP;
                        q_req_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    q_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Done pulses follow q_done combinationally, but only for an outstanding transfer.
    always_comb begin
        i_done = (state_q == S_BUSY) & q_done & q_i_d_q;
        d_done = (state_q == S_BUSY) & q_done & ~q_i_d_q;
        busy   = (state_q != S_IDLE);
    end

    assign q_req   = q_req_q;
    assign q_i_d   = q_i_d_q;
    assign q_write = q_write_q;
    assign q_mem   = q_mem_q;
    assign q_paddr = q_paddr_q;

endmodule

// File: tb/tb_qspi_arb.sv
// Bench for qspi_arb: directed scenarios plus random traffic, checked against
// a transaction-level reference model.
module tb_qspi_arb;

    localparam int unsigned PA = 24;
    localparam int unsigned LL = 4;
    localparam int unsigned DS = 2;
    localparam int unsigned TW = PA - $clog2(LL);

    logic          clk = 1'b0;
    logic          reset, rom_enable, i_req, d_req, d_write, q_done;
    logic [TW-1:0] i_tag, d_tag, q_paddr;
    logic          q_req, q_i_d, q_write, q_mem, i_done, d_done, busy;

    qspi_arb #(.PA(PA), .LINE_LENGTH(LL), .DSTREAK(DS)) dut (
        .clk(clk), .reset(reset), .rom_enable(rom_enable),
        .i_req(i_req), .i_tag(i_tag), .d_req(d_req), .d_write(d_write), .d_tag(d_tag),
        .q_done(q_done), .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem),
        .q_paddr(q_paddr), .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding transfer record plus a one-cycle cooldown.
    bit            m_xfer, m_cool;
    int            m_streak;
    bit            m_i, m_w, m_mem;
    logic [TW-1:0] m_paddr;

    bit   obs_order[$];
    bit   exp_order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit            s_rst, s_rom, s_ir, s_dr, s_dw, s_qd, iw;
        logic [TW-1:0] s_it, s_dt;
        #2;
        chk("i_done", 32'(i_done), 32'(m_xfer & q_done & m_i));
        chk("d_done", 32'(d_done), 32'(m_xfer & q_done & ~m_i));
        s_rst = reset; s_rom = rom_enable; s_ir = i_req; s_dr = d_req;
        s_dw = d_write; s_qd = q_done; s_it = i_tag; s_dt = d_tag;
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_xfer = 0; m_cool = 0; m_streak = 0;
            m_i = 0; m_w = 0; m_mem = 0; m_paddr = '0;
        end else if (m_xfer) begin
            if (s_qd) begin
                m_xfer = 0;
                m_cool = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (s_ir || s_dr) begin
            iw = s_ir && (!s_dr || m_streak == DS);
            if (iw || !s_ir) m_streak = 0;
            else m_streak = (m_streak + 1 > DS) ? DS : m_streak + 1;
            m_i     = iw;
            m_w     = iw ? 1'b0 : s_dw;
            m_mem   = s_rom && (iw || !s_dw);
            m_paddr = iw ? s_it : s_dt;
            m_xfer  = 1;
        end
        chk("q_req",   32'(q_req),   32'(m_xfer));
        chk("busy",    32'(busy),    32'(m_xfer | m_cool));
        chk("q_i_d",   32'(q_i_d),   32'(m_i));
        chk("q_write", 32'(q_write), 32'(m_w));
        chk("q_mem",   32'(q_mem),   32'(m_mem));
        chk("q_paddr", 32'(q_paddr), 32'(m_paddr));
    endtask

    task automatic wait_req();
        for (int k = 0; k < 8 && q_req !== 1'b1; k++) step();
        chk("q_req_wait", 32'(q_req), 32'd1);
    endtask

    // Run one transfer to completion while the request inputs stay as they are.
    task automatic run_xfer();
        wait_req();
        obs_order.push_back(q_i_d);
        step();
        step();
        q_done = 1'b1;
        step();
        q_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rom_enable = 1'b0; i_req = 1'b0; d_req = 1'b0;
        d_write = 1'b0; q_done = 1'b0; i_tag = '0; d_tag = '0;
        step();
        step();
        chk("rst_q_req", 32'(q_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Icache fill with ROM mapping active.
        i_req = 1'b1; i_tag = TW'(32'h12345); rom_enable = 1'b1;
        step();
        chk("t1_q_req", 32'(q_req), 32'd1);
        chk("t1_q_i_d", 32'(q_i_d), 32'd1);
        chk("t1_q_mem", 32'(q_mem), 32'd1);
        chk("t1_paddr", 32'(q_paddr), 32'h12345);
        i_req = 1'b0;
        step();
        q_done = 1'b1;
        #1;
        chk("t1_i_done", 32'(i_done), 32'd1);
        step();
        q_done = 1'b0;
        chk("t1_q_req_drop", 32'(q_req), 32'd0);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        step();
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Dcache push, then a pull raised during the gap cycle.
        d_req = 1'b1; d_write = 1'b1; d_tag = TW'(32'h00A10);
        step();
        chk("t2_q_write", 32'(q_write), 32'd1);
        chk("t2_q_mem", 32'(q_mem), 32'd0);
        chk("t2_q_i_d", 32'(q_i_d), 32'd0);
        q_done = 1'b1;
        #1;
        chk("t2_d_done", 32'(d_done), 32'd1);
        step();
        q_done = 1'b0;
        d_write = 1'b0; d_tag = TW'(32'h00B20);
        step();
        step();
        chk("t2_q_req2", 32'(q_req), 32'd1);
        chk("t2_paddr2", 32'(q_paddr), 32'h00B20);
        chk("t2_q_mem2", 32'(q_mem), 32'd1);
        chk("t2_q_write2", 32'(q_write), 32'd0);
        d_req = 1'b0;
        q_done = 1'b1;
        step();
        q_done = 1'b0;
        step();

        // Fairness with both requesters held high from a clean streak.
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_tag = TW'(32'h111); d_tag = TW'(32'h222);
        exp_order = '{0, 0, 1, 0, 0, 1};
        for (int t = 0; t < 6; t++) run_xfer();
        for (int t = 0; t < 6; t++) chk("grant_order", 32'(obs_order[t]), 32'(exp_order[t]));
        i_req = 1'b0; d_req = 1'b0;
        for (int t = 0; t < 4; t++) step();

        // Reset during a transfer abandons it silently; held request is re-granted.
        d_req = 1'b1; d_write = 1'b0;
        wait_req();
        step();
        reset = 1'b1;
        step();
        chk("t4_q_req_rst", 32'(q_req), 32'd0);
        chk("t4_busy_rst", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        chk("t4_regrant", 32'(q_req), 32'd1);

        // Requester withdraws mid-transfer; done still pulses, stray q_done ignored.
        d_req = 1'b0;
        step();
        q_done = 1'b1;
        #1;
        chk("t5_d_done_drop", 32'(d_done), 32'd1);
        step();
        step();
        step();
        chk("t5_idle_qdone", 32'(busy), 32'd0);
        q_done = 1'b0;
        step();

        // Random traffic, including input churn while busy and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            rom_enable = 1'($urandom);
            i_req      = ($urandom_range(0, 2) != 0);
            d_req      = ($urandom_range(0, 2) != 0);
            d_write    = 1'($urandom);
            i_tag      = TW'($urandom);
            d_tag      = TW'($urandom);
            q_done     = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Arbiter and sequencer for the single QSPI line-transfer engine.
- Shares the engine between three kinds of request: icache line fills, dcache line fills (pull) and dcache line write-backs (push).
- Captures the winning requester's tag, direction and memory select, and holds them stable for the whole transfer.
- Sits between the icache/dcache miss logic and the qspi block, replacing the direct ifetch-based request muxing in the top level.

Parameters:
- PA, 24, physical address width.
- LINE_LENGTH, 4, cache line length in bytes; tag width TW = PA - clog2(LINE_LENGTH).
- DSTREAK, 2, maximum consecutive dcache grants while an icache request is waiting; range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rom_enable  in  1  boot-ROM mapping active
- i_req  in  1  icache needs a line fill
- i_tag  in  TW  icache line address
- d_req  in  1  dcache needs a line transfer
- d_write  in  1  dcache transfer is a push (write-back) when 1, a pull when 0
- d_tag  in  TW  dcache line address
- q_done  in  1  one-cycle pulse from qspi: current line transfer complete
- q_req  out  1  request to qspi; held for the whole transfer
- q_i_d  out  1  1 = transfer belongs to the icache
- q_write  out  1  1 = write (push) transfer
- q_mem  out  1  ROM select
- q_paddr  out  TW  line address for the transfer
- i_done  out  1  icache transfer complete (one-cycle pulse)
- d_done  out  1  dcache transfer complete (one-cycle pulse)
- busy  out  1  arbiter state is not IDLE

Behaviour:
- States: IDLE, BUSY, GAP. Encoding is free.
- Reset: state=IDLE; q_req, q_i_d, q_write, q_mem, i_done, d_done, busy all 0; q_paddr=0; streak counter=0. A reset mid-transfer abandons the transfer immediately, with no done pulse.
- IDLE, no request: stays in IDLE.
- IDLE, request present: the winner is chosen by the arbitration rules below. On the next edge the arbiter moves to BUSY and registers:
  - q_i_d = 1 if the icache won.
  - q_write = d_write if the dcache won, else 0.
  - q_paddr = the winner's tag.
  - q_mem = rom_enable & (icache won | ~d_write).
- Arbitration:
  - The dcache wins by default.
  - The icache wins when i_req=1 and d_req=0, or when i_req=1 and streak == DSTREAK.
- Streak counter:
  - Incremented (saturating at DSTREAK) on each dcache grant made while i_req=1.
  - Cleared on every icache grant and on any dcache grant made while i_req=0.
- BUSY:
  - q_req=1 and all captured fields are constant.
  - Request inputs, tag inputs and rom_enable are ignored.
  - On q_done=1: i_done (if q_i_d) or d_done (if ~q_i_d) is asserted combinationally in that same cycle; the next state is GAP and q_req drops at that edge.
- A requester dropping its req while BUSY does not abort the transfer; the done pulse is still issued.
- GAP:
  - Lasts exactly one cycle with q_req=0, then goes to IDLE.
  - The requester must deassert or update its req during this cycle. This lets the dcache raise a pull straight after its push.
- q_done while in IDLE or GAP is ignored and produces no done pulse.
- Latency:
  - req sampled in IDLE at cycle N gives q_req=1 at N+1.
  - q_done at cycle M gives q_req=0 at M+1 and IDLE at M+2.
  - Earliest new grant is therefore evaluated at M+2, with q_req high again at M+3.
- At most one transfer is outstanding at any time; done pulses are mutually exclusive.
- busy = (state != IDLE).

Test Plan:
- i_req=1, i_tag=0x12345, rom_enable=1, d_req=0 -> q_req=1 one cycle later with q_i_d=1, q_write=0, q_mem=1, q_paddr=0x12345; q_done pulse -> i_done=1 in the same cycle; q_req=0 next cycle; busy=0 two cycles after q_done.
- d_req=1, d_write=1, d_tag=0x00A10, rom_enable=1 -> q_write=1, q_mem=0, q_i_d=0. After d_done, in the GAP cycle switch to d_write=0, d_tag=0x00B20 -> second grant is a pull with q_mem=1 and q_paddr=0x00B20.
- i_req and d_req both held high, DSTREAK=2 -> grant order D, D, I, D, D, I; streak returns to 0 after each I grant.
- Reset asserted during BUSY (no q_done) -> next cycle IDLE, q_req=0, no i_done/d_done pulse; a request held through reset is granted on the second cycle after reset drops.
- q_done pulsed while IDLE and while in GAP -> no state change, no done pulse; d_req dropped mid-BUSY -> d_done still pulses on q_done.
- While BUSY, change i_tag/d_tag/d_write/rom_enable every cycle -> q_paddr, q_write, q_mem stay at their captured values until GAP.
